// File: rtl/taxi_pcie_irq_pkg.sv
// Shared types and helpers for the PCIe interrupt path.
// Used by the IRQ scheduler and the MSI-X stage.
package taxi_pcie_irq_pkg;

  localparam int IRQ_CNT_MAX = 256;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } irq_state_e;

  function automatic int irq_index_w(input int cnt);
    return $clog2(cnt);
  endfunction

endpackage

// File: rtl/taxi_axis_if.sv
// Minimal AXI-stream interface: tdata with a valid/ready handshake.
// Source drives tdata/tvalid, sink drives tready.
interface taxi_axis_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport src (
    output tdata,
    output tvalid,
    input  tready
  );

  modport snk (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/taxi_pcie_irq_rr_sel.sv
// Combinational round-robin select: first set bit at or above i_ptr,
// wrapping to the lowest set bit when nothing lies above the pointer.
module taxi_pcie_irq_rr_sel #(
  parameter int W  = 64,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  logic          w_hi_vld;
  logic [IW-1:0] w_hi_idx;
  logic          w_lo_vld;
  logic [IW-1:0] w_lo_idx;

  // Downward scan so the last hit is the lowest index.
  always_comb begin
    w_hi_vld = 1'b0;
    w_hi_idx = '0;
    w_lo_vld = 1'b0;
    w_lo_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_req[i] && (i >= int'(i_ptr))) begin
        w_hi_vld = 1'b1;
        w_hi_idx = IW'(i);
      end
      if (i_req[i]) begin
        w_lo_vld = 1'b1;
        w_lo_idx = IW'(i);
      end
    end
  end

  assign o_valid = w_lo_vld;
  assign o_idx   = w_hi_vld ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/taxi_pcie_irq_rr_sched.sv
// Pending-vector IRQ collector with round-robin issue onto an AXI stream.
// Optional issue throttle: define TAXI_PCIE_IRQ_HOLDOFF_EN.
module taxi_pcie_irq_rr_sched
  import taxi_pcie_irq_pkg::*;
#(
  parameter int IRQ_CNT   = 64,
  parameter int HOLDOFF_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IRQ_CNT-1:0]   irq_req,
  input  logic                 enable,
  input  logic [HOLDOFF_W-1:0] holdoff,
  taxi_axis_if.src             m_axis_irq,
  output logic [IRQ_CNT-1:0]   pending
);

  localparam int IW = irq_index_w(IRQ_CNT);

  irq_state_e         r_state;
  irq_state_e         w_state_nx;
  logic [IRQ_CNT-1:0] r_pend;
  logic [IRQ_CNT-1:0] r_stat;
  logic [IRQ_CNT-1:0] w_pend_nx;
  logic [IRQ_CNT-1:0] w_clr;
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_data;
  logic [IW-1:0]      w_sel_idx;
  logic [IW-1:0]      w_ptr_nx;
  logic               w_sel_vld;
  logic               w_vld;
  logic               w_hs;
  logic               w_hold_ok;
  logic               w_load;

  taxi_pcie_irq_rr_sel #(
    .W  (IRQ_CNT),
    .IW (IW)
  ) u_sel (
    .i_req   (r_pend),
    .i_ptr   (r_ptr),
    .o_valid (w_sel_vld),
    .o_idx   (w_sel_idx)
  );

  assign w_vld  = (r_state == ST_PRESENT);
  assign w_hs   = w_vld && m_axis_irq.tready;
  assign w_load = enable && w_sel_vld && w_hold_ok
                  && (!w_vld || m_axis_irq.tready);

`ifdef TAXI_PCIE_IRQ_HOLDOFF_EN
  logic [HOLDOFF_W-1:0] r_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (w_hs) begin
      r_hold <= holdoff;
    end else if (r_hold != '0) begin
      r_hold <= r_hold - HOLDOFF_W'(1);
    end
  end

  // A throttling handshake also blocks the load on its own edge.
  assign w_hold_ok = (r_hold == '0) && !(w_hs && (holdoff != '0));
`else
  logic w_unused_holdoff;
  assign w_unused_holdoff = ^holdoff;
  assign w_hold_ok        = 1'b1;
`endif

  assign w_clr     = w_load ? (IRQ_CNT'(1) << w_sel_idx) : '0;
  assign w_pend_nx = (r_pend & ~w_clr) | irq_req;
  assign w_ptr_nx  = (w_sel_idx == IW'(IRQ_CNT - 1))
                     ? '0 : w_sel_idx + IW'(1);

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_load) w_state_nx = ST_PRESENT;
      ST_PRESENT: if (w_hs && !w_load) w_state_nx = ST_IDLE;
      default:    w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_stat  <= '0;
      r_ptr   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pend  <= w_pend_nx;
      r_stat  <= w_pend_nx;
      if (w_load) begin
        r_ptr  <= w_ptr_nx;
        r_data <= w_sel_idx;
      end
    end
  end

  assign m_axis_irq.tdata  = r_data;
  assign m_axis_irq.tvalid = w_vld;
  assign pending           = r_stat;

endmodule

// File: tb/tb_taxi_pcie_irq_rr_sched.sv
// Directed bench for taxi_pcie_irq_rr_sched with a queue-based scoreboard.
// Holdoff case is compiled in when TAXI_PCIE_IRQ_HOLDOFF_EN is defined.
module tb_taxi_pcie_irq_rr_sched;

  localparam int N  = 64;
  localparam int IW = 6;
  localparam int HW = 16;

  typedef struct {
    int idx;
    int lo;
    int hi;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  irq_req;
  logic          enable;
  logic [HW-1:0] holdoff;
  logic [N-1:0]  pending;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  exp_t          exp_q[$];

  taxi_axis_if #(.DATA_W(IW)) axis ();

  taxi_pcie_irq_rr_sched #(
    .IRQ_CNT   (N),
    .HOLDOFF_W (HW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_req    (irq_req),
    .enable     (enable),
    .holdoff    (holdoff),
    .m_axis_irq (axis),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input int lo, input int hi);
    exp_t e;
    e.idx = idx;
    e.lo  = lo;
    e.hi  = hi;
    exp_q.push_back(e);
  endtask

  task automatic strobe(input logic [N-1:0] v);
    irq_req = v;
    tick();
    irq_req = '0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout left=%0d", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && axis.tvalid && axis.tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected got=%0d cyc=%0d", axis.tdata, cyc);
        end else begin
          e = exp_q.pop_front();
          if (int'(axis.tdata) != e.idx || cyc < e.lo || cyc > e.hi) begin
            errors++;
            $display("FAIL beat got=%0d@%0d exp=%0d@[%0d..%0d]",
                     axis.tdata, cyc, e.idx, e.lo, e.hi);
          end
        end
      end
    end
  endtask

  initial begin
    int c;
    logic [N-1:0] v;
    rst_n       = 1'b0;
    irq_req     = '0;
    enable      = 1'b0;
    holdoff     = '0;
    axis.tready = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
    chk("rst_tdata", 64'(axis.tdata), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);

    // single request, exact two-cycle latency
    enable      = 1'b1;
    axis.tready = 1'b1;
    c = cyc;
    push(5, c + 2, c + 2);
    strobe(N'(1) << 5);
    wait_drain(20);
    chk("single_pending", 64'(pending), 64'd0);

    // coalescing: four strobes latched while disabled
    enable      = 1'b0;
    axis.tready = 1'b0;
    irq_req     = N'(1) << 9;
    repeat (4) tick();
    irq_req = '0;
    repeat (2) tick();
    chk("coal_pending", 64'(pending), 64'h200);
    chk("coal_novalid", 64'(axis.tvalid), 64'd0);
    enable = 1'b1;
    repeat (3) tick();
    chk("coal_stall_valid", 64'(axis.tvalid), 64'd1);
    chk("coal_stall_data", 64'(axis.tdata), 64'd9);
    chk("coal_cleared", 64'(pending), 64'd0);
    push(9, 0, 1 << 30);
    axis.tready = 1'b1;
    wait_drain(20);
    repeat (3) tick();

    // round-robin from ptr 11 (after issuing 10)
    push(10, 0, 1 << 30);
    strobe(N'(1) << 10);
    wait_drain(20);
    c = cyc;
    push(40, c + 2, c + 2);
    push(3, c + 3, c + 3);
    push(10, c + 4, c + 4);
    v = (N'(1) << 3) | (N'(1) << 10) | (N'(1) << 40);
    strobe(v);
    wait_drain(20);
    chk("rr_pending", 64'(pending), 64'd0);

    // collision: re-strobe on the load cycle
    c = cyc;
    push(7, c + 2, c + 2);
    push(7, c + 3, c + 3);
    irq_req = N'(1) << 7;
    tick();
    tick();
    irq_req = '0;
    wait_drain(20);
    chk("coll_pending", 64'(pending), 64'd0);

    // enable gating
    enable = 1'b0;
    strobe((N'(1) << 1) | (N'(1) << 2));
    repeat (3) tick();
    chk("en_novalid", 64'(axis.tvalid), 64'd0);
    chk("en_pending", 64'(pending), 64'h6);
    c = cyc;
    push(1, c + 1, c + 1);
    push(2, c + 2, c + 2);
    enable = 1'b1;
    wait_drain(20);
    chk("en_pending_end", 64'(pending), 64'd0);

`ifdef TAXI_PCIE_IRQ_HOLDOFF_EN
    // ptr is 3 here, so 0 wraps in only after the scan passes 63
    holdoff = 16'd10;
    c = cyc;
    push(0, c + 2, c + 2);
    push(1, c + 13, c + 20);
    strobe((N'(1) << 0) | (N'(1) << 1));
    wait_drain(40);
    holdoff = '0;
    repeat (12) tick();
`endif

    // reset during a stalled beat
    axis.tready = 1'b0;
    strobe((N'(1) << 20) | (N'(1) << 21));
    repeat (3) tick();
    chk("stall_valid", 64'(axis.tvalid), 64'd1);
    chk("stall_data", 64'(axis.tdata), 64'd20);
    rst_n = 1'b0;
    tick();
    chk("midrst_tvalid", 64'(axis.tvalid), 64'd0);
    chk("midrst_pending", 64'(pending), 64'd0);
    chk("midrst_tdata", 64'(axis.tdata), 64'd0);
    rst_n = 1'b1;
    tick();

    // wrap boundary: issue 63 so ptr wraps to 0
    axis.tready = 1'b1;
    c = cyc;
    push(63, c + 2, c + 2);
    strobe(N'(1) << 63);
    wait_drain(20);
    c = cyc;
    push(0, c + 2, c + 2);
    push(62, c + 3, c + 3);
    strobe((N'(1) << 0) | (N'(1) << 62));
    wait_drain(20);
    chk("wrap_pending", 64'(pending), 64'd0);

    repeat (5) tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
